// File: rtl/ifns_encoder_seq_23.sv
// ---------------------------------------------------------------------------
// ifns_encoder_seq_23
//   Sequential IFNS transmitter stage. Accepts a 16-bit data word over a
//   valid/ready handshake and resolves one Fibonacci-weighted digit per cycle,
//   MSB first, producing a 23-bit codeword with no two adjacent 1s. The
//   finished codeword is presented with a valid/ready handshake.
//
//   Code bit k (k = 1..23) carries weight Fib(k+1): bit1 = 1, bit2 = 2,
//   bit3 = 3, bit4 = 5, ... bit23 = 46368.
//
// Ports
//   clock      in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   datain     in  16   data word, sampled on in_valid & in_ready
//   in_valid   in   1   datain is valid
//   in_ready   out  1   block is idle and can accept a word
//   codeout    out 23   encoded codeword [23:1], stable while out_valid
//   out_valid  out  1   codeout holds a complete codeword
//   out_ready  in   1   downstream accepts codeout
//   code_err   out  1   sticky self-check error flag
//
// Configuration
//   IFNS_ENC_CHECK_EN : when defined, a registered self-check on entry to
//   DONE flags a non-zero final remainder or adjacent 1s in the codeword.
//   When undefined, code_err is tied low.
// ---------------------------------------------------------------------------
module ifns_encoder_seq_23 (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] datain,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:1] codeout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        code_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REM_W  = DATA_W + 1;
  localparam int unsigned CODE_W = 23;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [REM_W-1:0]    r_rem;
  logic [CODE_W-1:0]   r_shift;
  logic [CODE_W-1:0]   r_codeout;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [REM_W-1:0]    w_weight;
  logic                w_take;
  logic [REM_W-1:0]    w_rem_next;
  logic [CODE_W-1:0]   w_shift_next;
  logic                w_last_digit;

  // Constant weight table: digit k -> Fib(k+1); unused indices return 0
  function automatic logic [REM_W-1:0] fib_weight(input logic [CNT_W-1:0] k);
    logic [REM_W-1:0] w;
    w = '0;
    case (k)
      5'd1:  w = 17'd1;
      5'd2:  w = 17'd2;
      5'd3:  w = 17'd3;
      5'd4:  w = 17'd5;
      5'd5:  w = 17'd8;
      5'd6:  w = 17'd13;
      5'd7:  w = 17'd21;
      5'd8:  w = 17'd34;
      5'd9:  w = 17'd55;
      5'd10: w = 17'd89;
      5'd11: w = 17'd144;
      5'd12: w = 17'd233;
      5'd13: w = 17'd377;
      5'd14: w = 17'd610;
      5'd15: w = 17'd987;
      5'd16: w = 17'd1597;
      5'd17: w = 17'd2584;
      5'd18: w = 17'd4181;
      5'd19: w = 17'd6765;
      5'd20: w = 17'd10946;
      5'd21: w = 17'd17711;
      5'd22: w = 17'd28657;
      5'd23: w = 17'd46368;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Greedy digit decision for the digit currently addressed by r_cnt
  always_comb begin
    w_weight     = fib_weight(r_cnt);
    w_take       = (r_rem >= w_weight);
    w_rem_next   = w_take ? (r_rem - w_weight) : r_rem;
    w_shift_next = {r_shift[CODE_W-2:0], w_take};
    w_last_digit = (r_cnt == CNT_W'(1));
  end

  // Control FSM with registered outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_codeout   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_rem      <= REM_W'(datain);
            r_shift    <= '0;
            r_cnt      <= CNT_W'(CODE_W);
            r_in_ready <= 1'b0;
            r_state    <= ST_ENC;
          end else begin
            // Also raises in_ready on the first edge after reset release
            r_in_ready <= 1'b1;
          end
        end
        ST_ENC: begin
          r_rem   <= w_rem_next;
          r_shift <= w_shift_next;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_last_digit) begin
            // codeout is only updated here so it never glitches downstream
            r_codeout   <= w_shift_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IFNS_ENC_CHECK_EN
  logic r_code_err;
  logic w_adjacent;

  // Adjacent-ones detector on the codeword about to be registered
  always_comb begin
    w_adjacent = |(w_shift_next[CODE_W-1:1] & w_shift_next[CODE_W-2:0]);
  end

  // Sticky self-check captured on entry to DONE
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_code_err <= 1'b0;
    end else if ((r_state == ST_ENC) && w_last_digit) begin
      r_code_err <= r_code_err | (w_rem_next != '0) | w_adjacent;
    end
  end

  assign code_err = r_code_err;
`else
  assign code_err = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign codeout   = r_codeout;

endmodule
